tmc_meas_sched: RTL and testbench
=================================

# tmc_meas_sched

Measurement scheduler for the Temperature Measurement and Control (TMC) firmware. It sequences one shared thermistor ADC across up to N_CH multiplexed sensor channels:
- selects a channel;
- waits a settling time;
- issues a conversion start and collects the result;
- repeats the scan at a fixed period.

It sits in `tmc_firmware_top` between the board's analog mux/ADC interface logic and the temperature-control loop that consumes results. It runs on the board reference clock.

## Interface
- N_CH, 8: number of mux channels (2..16).
- CH_W, 3: channel index width, equal to clog2(N_CH).
- DATA_W, 24: ADC result width.
- SETTLE_CYC, 1000: clk cycles from mux change to conversion start (≥1).
- TIMEOUT_CYC, 65535: clk cycles to wait for adc_done before declaring timeout (≥2).
- PERIOD_CYC, 100000: clk cycles between scan starts (≥1).
- clk  in  1  system clock, driven from R_CLK.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run periodic scans.
- ch_mask  in  N_CH  channel enables; bit i = scan channel i.
- err_clr  in  1  one-cycle pulse; clears timeout_flag and overrun_flag.
- mux_sel  out  CH_W  analog mux channel select.
- mux_en  out  1  analog mux enable.
- adc_start  out  1  one-cycle conversion start pulse.
- adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
- adc_data  in  DATA_W  conversion result.
- res_valid  out  1  one-cycle pulse; res_ch and res_data are valid.
- res_ch  out  CH_W  channel of the result.
- res_data  out  DATA_W  captured adc_data.
- scan_done  out  1  one-cycle pulse after the last enabled channel of a scan.
- busy  out  1  1 in every state except IDLE.
- timeout_flag  out  1  sticky; a conversion timed out.
- overrun_flag  out  1  sticky; a scan took longer than PERIOD_CYC.

## Operation
- **States:** IDLE, SETTLE, CONVERT, WAIT_PERIOD.
- **IDLE**
  - When enable=1 and ch_mask≠0: latch ch_mask into scan_mask.
  - Clear the period counter.
  - Load mux_sel with the lowest set bit, set mux_en=1, and go to SETTLE.
- **SETTLE**
  - The settle counter counts SETTLE_CYC cycles.
  - On expiry, pulse adc_start and go to CONVERT.
- **CONVERT**
  - On adc_done: capture adc_data into res_data and mux_sel into res_ch, and pulse res_valid.
  - On TIMEOUT_CYC cycles without adc_done: set timeout_flag; no res_valid is produced.
  - In either case, advance to the next set bit of scan_mask above the current index.
    - If such a bit exists: update mux_sel and go to SETTLE.
    - If none exists: pulse scan_done, set mux_en=0, and go to WAIT_PERIOD.
- **WAIT_PERIOD**
  - When the period counter reaches PERIOD_CYC−1, clear it, re-latch ch_mask and start a new scan. This applies only if enable=1 and ch_mask≠0; otherwise go to IDLE.
- **Period counter**
  - It counts every cycle from scan start.
  - If it reaches PERIOD_CYC−1 before scan_done: set overrun_flag. The next scan then starts on the cycle after scan_done, with no WAIT_PERIOD residency.
  - The counter saturates at PERIOD_CYC−1.
- **Mask timing:** ch_mask changes mid-scan take effect at the next scan start.
- **enable=0 in SETTLE or WAIT_PERIOD:** go to IDLE on the next edge with mux_en=0. No adc_start is issued.
- **enable=0 in CONVERT:** the conversion completes (result or timeout) before going to IDLE. The ADC is never abandoned mid-conversion.
- **err_clr:** clears both sticky flags. A flag-setting event in the same cycle wins, so the flag is left at 1.
- **Reset values:** state=IDLE and every output 0 (mux_sel=0, mux_en=0, adc_start=0, res_valid=0, res_ch=0, res_data=0, scan_done=0, busy=0, both flags 0).
- **Reset mid-scan:** all counters and outputs return to reset values on the next edge, with no further adc_start.

## Timing
- All outputs are registered.
- **Scan start:** enable sampled 1 at edge k → mux_sel/mux_en valid from edge k+1.
- **Settle:** adc_start is high exactly SETTLE_CYC cycles after mux_sel changes, for 1 cycle.
- **Result:** adc_done sampled at edge d → res_valid/res_ch/res_data valid at edge d+1. mux_sel changes to the next channel at the same edge d+1.
- **Done before start:** adc_done in the same cycle as adc_start, or in SETTLE, is ignored.
- **Timeout:** declared at the TIMEOUT_CYC-th edge after adc_start with no done. timeout_flag is set at that edge.
- **Scan end:** scan_done and res_valid of the last channel assert in the same cycle.
- **Period:** scan-start to scan-start spacing is exactly PERIOD_CYC cycles when no overrun occurs.

## Structure
- Shared package `tmc_pkg` holds:
  - the state enum (IDLE, SETTLE, CONVERT, WAIT_PERIOD);
  - the default parameter constants;
  - the CH_W derivation function.
- Sub-module `tmc_next_ch`: combinational search for the next set bit of scan_mask strictly above the current index. Outputs are next_ch and found, plus a first_ch output for scan start.
- Counters: one settle/timeout down-counter (shared by SETTLE and CONVERT) and one period up-counter, each sized by clog2 of its maximum.

## Test plan
All scenarios use SETTLE_CYC=4, TIMEOUT_CYC=20, PERIOD_CYC=100, N_CH=8.
- **Single scan:** ch_mask=8'b1000_0101, ADC model answers 3 cycles after adc_start with data=ch*16.
  - Results on channels 0, 2, 7 with data 0, 32, 112.
  - scan_done coincides with the ch7 res_valid.
  - Next adc_start on ch0 falls 100 cycles after the first scan start + 1 + 4.
- **Settle timing:** check that adc_start falls exactly 4 cycles after each mux_sel change.
- **Timeout:** the ADC never answers on ch2.
  - timeout_flag=1 at adc_start+20.
  - No res_valid for ch2; the scan continues to ch7.
  - err_clr then clears the flag.
- **Overrun:** PERIOD_CYC=30 with 3 channels → overrun_flag=1. Each new scan starts the cycle after scan_done.
- **Disable:**
  - enable→0 during CONVERT → the result is still delivered, then busy=0 and mux_en=0.
  - enable→0 during SETTLE → no adc_start.
- **Reset:** rst asserted in CONVERT → all outputs 0 next edge; a late adc_done produces no res_valid.

Source files
------------

// File: rtl/tmc_pkg.sv
// tmc_pkg
// Shared definitions for the TMC measurement scheduler:
//   - tmc_state_e       : scheduler FSM states
//   - TMC_*_DEF         : default parameter values for the scheduler
//   - tmc_clog2_min1    : clog2 that never returns 0, used to size counters
//   - tmc_ch_width      : channel index width derived from the channel count
package tmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SETTLE      = 2'd1,
        ST_CONVERT     = 2'd2,
        ST_WAIT_PERIOD = 2'd3
    } tmc_state_e;

    localparam int TMC_N_CH_DEF        = 8;
    localparam int TMC_DATA_W_DEF      = 24;
    localparam int TMC_SETTLE_CYC_DEF  = 1000;
    localparam int TMC_TIMEOUT_CYC_DEF = 65535;
    localparam int TMC_PERIOD_CYC_DEF  = 100000;

    // Width needed to hold values 0..n-1, but never less than one bit so
    // that degenerate counters still produce a legal vector.
    function automatic int tmc_clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tmc_ch_width(input int n_ch);
        return tmc_clog2_min1(n_ch);
    endfunction

endpackage

// File: rtl/tmc_next_ch.sv
// tmc_next_ch
// Combinational channel search for the scheduler.
// Ports:
//   scan_mask  in   mask latched for the scan in progress
//   cur_ch     in   channel currently selected on the mux
//   start_mask in   live channel mask, used when a new scan begins
//   next_ch    out  lowest set bit of scan_mask strictly above cur_ch
//   found      out  1 when next_ch is valid
//   first_ch   out  lowest set bit of start_mask (0 when the mask is empty)
module tmc_next_ch
    import tmc_pkg::*;
#(
    parameter int N_CH = TMC_N_CH_DEF,
    parameter int CH_W = tmc_ch_width(N_CH)
) (
    input  logic [N_CH-1:0] scan_mask,
    input  logic [CH_W-1:0] cur_ch,
    input  logic [N_CH-1:0] start_mask,
    output logic [CH_W-1:0] next_ch,
    output logic            found,
    output logic [CH_W-1:0] first_ch
);

    // Walking from the top index down means the last hit written is the
    // lowest qualifying bit, which is the priority both searches need.
    always_comb begin
        next_ch  = '0;
        found    = 1'b0;
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (scan_mask[i] && (i > int'(cur_ch))) begin
                next_ch = CH_W'(i);
                found   = 1'b1;
            end
            if (start_mask[i]) begin
                first_ch = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/tmc_meas_sched.sv
// tmc_meas_sched
// Sequences one shared ADC across N_CH multiplexed thermistor channels:
// select channel, settle, start conversion, collect result, repeat the scan
// every PERIOD_CYC cycles.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable, ch_mask     run request and per-channel scan enables
//   err_clr             pulse clearing the sticky error flags
//   mux_sel, mux_en     analog mux control
//   adc_start           one-cycle conversion start
//   adc_done, adc_data  conversion completion and result
//   res_valid, res_ch, res_data   result pulse with channel and data
//   scan_done           pulse with the final channel of each scan
//   busy                1 whenever the scheduler is not idle
//   timeout_flag        sticky, a conversion never completed
//   overrun_flag        sticky, a scan outlasted the scan period
module tmc_meas_sched
    import tmc_pkg::*;
#(
    parameter int N_CH        = TMC_N_CH_DEF,
    parameter int CH_W        = tmc_ch_width(N_CH),
    parameter int DATA_W      = TMC_DATA_W_DEF,
    parameter int SETTLE_CYC  = TMC_SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TMC_TIMEOUT_CYC_DEF,
    parameter int PERIOD_CYC  = TMC_PERIOD_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              err_clr,
    output logic [CH_W-1:0]   mux_sel,
    output logic              mux_en,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic [DATA_W-1:0] res_data,
    output logic              scan_done,
    output logic              busy,
    output logic              timeout_flag,
    output logic              overrun_flag
);

    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = tmc_clog2_min1(CNT_MAX);
    localparam int PER_W   = tmc_clog2_min1(PERIOD_CYC);

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PER_W-1:0] PER_LAST     = PER_W'(PERIOD_CYC - 1);

    tmc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [N_CH-1:0]   scan_mask_q, scan_mask_d;
    logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
    logic              mux_en_q, mux_en_d;
    logic              adc_start_q, adc_start_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              scan_done_q, scan_done_d;
    logic              busy_q, busy_d;
    logic              timeout_flag_q, timeout_flag_d;
    logic              overrun_flag_q, overrun_flag_d;

    logic [CH_W-1:0]   next_ch;
    logic [CH_W-1:0]   first_ch;
    logic              found;
    logic              start_scan;
    logic              conv_end;
    logic              done_ok;
    logic              per_sat;
    logic              can_start;
    logic              timeout_set;
    logic              overrun_set;

    tmc_next_ch #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_next_ch (
        .scan_mask  (scan_mask_q),
        .cur_ch     (mux_sel_q),
        .start_mask (ch_mask),
        .next_ch    (next_ch),
        .found      (found),
        .first_ch   (first_ch)
    );

    // Next-state logic. cnt_q is shared: it counts down the settle time in
    // SETTLE and the timeout window in CONVERT, reaching 0 on the expiry
    // cycle. The first CONVERT cycle is recognised by cnt_q still holding
    // TIMEOUT_LOAD; a done arriving then overlaps adc_start and is dropped.
    // per_q counts from every scan start and saturates on the last cycle of
    // the period; a saturated counter while the scan is still running marks
    // an overrun, and also lets WAIT_PERIOD restart on its very first cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        per_d          = per_q;
        scan_mask_d    = scan_mask_q;
        mux_sel_d      = mux_sel_q;
        mux_en_d       = mux_en_q;
        adc_start_d    = 1'b0;
        res_valid_d    = 1'b0;
        res_ch_d       = res_ch_q;
        res_data_d     = res_data_q;
        scan_done_d    = 1'b0;
        start_scan     = 1'b0;
        conv_end       = 1'b0;
        timeout_set    = 1'b0;
        overrun_set    = 1'b0;
        per_sat        = (per_q == PER_LAST);
        can_start      = enable && (ch_mask != '0);
        done_ok        = adc_done && (cnt_q != TIMEOUT_LOAD);

        if ((state_q != ST_IDLE) && !per_sat) begin
            per_d = per_q + PER_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                per_d = '0;
                if (can_start) begin
                    start_scan = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (per_sat) begin
                    overrun_set = 1'b1;
                end
                if (!enable) begin
                    mux_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == '0) begin
                    adc_start_d = 1'b1;
                    cnt_d       = TIMEOUT_LOAD;
                    state_d     = ST_CONVERT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (done_ok) begin
                    res_valid_d = 1'b1;
                    res_data_d  = adc_data;
                    res_ch_d    = mux_sel_q;
                    conv_end    = 1'b1;
                end else if (cnt_q == '0) begin
                    timeout_set = 1'b1;
                    conv_end    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (per_sat && !(conv_end && !found)) begin
                    overrun_set = 1'b1;
                end
                if (conv_end) begin
                    if (found && enable) begin
                        mux_sel_d = next_ch;
                        cnt_d     = SETTLE_LOAD;
                        state_d   = ST_SETTLE;
                    end else begin
                        mux_en_d    = 1'b0;
                        scan_done_d = !found;
                        state_d     = (!found && enable) ? ST_WAIT_PERIOD : ST_IDLE;
                    end
                end
            end
            ST_WAIT_PERIOD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (per_sat) begin
                    if (can_start) begin
                        start_scan = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_scan) begin
            per_d       = '0;
            scan_mask_d = ch_mask;
            mux_sel_d   = first_ch;
            mux_en_d    = 1'b1;
            cnt_d       = SETTLE_LOAD;
            state_d     = ST_SETTLE;
        end

        busy_d         = (state_d != ST_IDLE);
        timeout_flag_d = (timeout_flag_q && !err_clr) || timeout_set;
        overrun_flag_d = (overrun_flag_q && !err_clr) || overrun_set;
    end

    // State and output registers; reset returns everything to idle zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            per_q          <= '0;
            scan_mask_q    <= '0;
            mux_sel_q      <= '0;
            mux_en_q       <= 1'b0;
            adc_start_q    <= 1'b0;
            res_valid_q    <= 1'b0;
            res_ch_q       <= '0;
            res_data_q     <= '0;
            scan_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_flag_q <= 1'b0;
            overrun_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            per_q          <= per_d;
            scan_mask_q    <= scan_mask_d;
            mux_sel_q      <= mux_sel_d;
            mux_en_q       <= mux_en_d;
            adc_start_q    <= adc_start_d;
            res_valid_q    <= res_valid_d;
            res_ch_q       <= res_ch_d;
            res_data_q     <= res_data_d;
            scan_done_q    <= scan_done_d;
            busy_q         <= busy_d;
            timeout_flag_q <= timeout_flag_d;
            overrun_flag_q <= overrun_flag_d;
        end
    end

    assign mux_sel      = mux_sel_q;
    assign mux_en       = mux_en_q;
    assign adc_start    = adc_start_q;
    assign res_valid    = res_valid_q;
    assign res_ch       = res_ch_q;
    assign res_data     = res_data_q;
    assign scan_done    = scan_done_q;
    assign busy         = busy_q;
    assign timeout_flag = timeout_flag_q;
    assign overrun_flag = overrun_flag_q;

endmodule

// File: tb/tb_tmc_meas_sched.sv
// tb_tmc_meas_sched
// Directed bench for tmc_meas_sched. The main instance runs with a 100-cycle
// period; a second instance with a 30-cycle period and a slow ADC exercises
// overrun. Offsets "rel" count clock edges from the scan-start edge (the edge
// that samples enable=1); outputs are sampled and inputs driven on negedges.
module tb_tmc_meas_sched;

    localparam int N_CH   = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              enable = 1'b0;
    logic [N_CH-1:0]   ch_mask = '0;
    logic              err_clr = 1'b0;
    logic [CH_W-1:0]   mux_sel;
    logic              mux_en;
    logic              adc_start;
    logic              adc_done = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;
    logic              scan_done;
    logic              busy;
    logic              timeout_flag;
    logic              overrun_flag;

    logic              enable_2 = 1'b0;
    logic [N_CH-1:0]   ch_mask_2 = '0;
    logic              err_clr_2 = 1'b0;
    logic [CH_W-1:0]   mux_sel_2;
    logic              mux_en_2;
    logic              adc_start_2;
    logic              adc_done_2 = 1'b0;
    logic [DATA_W-1:0] adc_data_2 = '0;
    logic              res_valid_2;
    logic [CH_W-1:0]   res_ch_2;
    logic [DATA_W-1:0] res_data_2;
    logic              scan_done_2;
    logic              busy_2;
    logic              timeout_flag_2;
    logic              overrun_flag_2;

    int vectors     = 0;
    int miscompares = 0;

    int lat_1    = 3;
    int silent_1 = -1;
    int rem_1    = 0;
    int lat_2    = 10;
    int rem_2    = 0;

    always #5 clk = ~clk;

    tmc_meas_sched #(
        .N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W),
        .SETTLE_CYC(4), .TIMEOUT_CYC(20), .PERIOD_CYC(100)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .err_clr(err_clr),
        .mux_sel(mux_sel), .mux_en(mux_en), .adc_start(adc_start),
        .adc_done(adc_done), .adc_data(adc_data),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .scan_done(scan_done), .busy(busy),
        .timeout_flag(timeout_flag), .overrun_flag(overrun_flag)
    );

    tmc_meas_sched #(
        .N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W),
        .SETTLE_CYC(4), .TIMEOUT_CYC(20), .PERIOD_CYC(30)
    ) dut_ovr (
        .clk(clk), .rst(rst), .enable(enable_2), .ch_mask(ch_mask_2), .err_clr(err_clr_2),
        .mux_sel(mux_sel_2), .mux_en(mux_en_2), .adc_start(adc_start_2),
        .adc_done(adc_done_2), .adc_data(adc_data_2),
        .res_valid(res_valid_2), .res_ch(res_ch_2), .res_data(res_data_2),
        .scan_done(scan_done_2), .busy(busy_2),
        .timeout_flag(timeout_flag_2), .overrun_flag(overrun_flag_2)
    );

    // ADC model for the main instance: answers lat_1 edges after adc_start
    // with data = channel*16, except on the channel named by silent_1.
    always @(negedge clk) begin
        adc_done = 1'b0;
        if (rem_1 > 0) begin
            rem_1--;
            if (rem_1 == 0) adc_done = 1'b1;
        end
        if (adc_start === 1'b1 && int'(mux_sel) != silent_1) begin
            adc_data      = '0;
            adc_data[6:0] = {mux_sel, 4'b0000};
            rem_1         = lat_1 - 1;
            if (rem_1 == 0) adc_done = 1'b1;
        end
    end

    // ADC model for the overrun instance: always answers, lat_2 edges late.
    always @(negedge clk) begin
        adc_done_2 = 1'b0;
        if (rem_2 > 0) begin
            rem_2--;
            if (rem_2 == 0) adc_done_2 = 1'b1;
        end
        if (adc_start_2 === 1'b1) begin
            adc_data_2      = '0;
            adc_data_2[6:0] = {mux_sel_2, 4'b0000};
            rem_2           = lat_2 - 1;
            if (rem_2 == 0) adc_done_2 = 1'b1;
        end
    end

    // Reset dominates a pending enable; every output of both instances is 0.
    task automatic test_reset();
        logic [36:0] obs;
        rst = 1'b1; enable = 1'b1; ch_mask = 8'hFF; enable_2 = 1'b1; ch_mask_2 = 8'h07;
        repeat (3) @(negedge clk);
        obs = {mux_sel, mux_en, adc_start, res_valid, res_ch, res_data,
               scan_done, busy, timeout_flag, overrun_flag};
        vectors++;
        if (obs !== 37'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %0h, expected 0", obs);
        end
        vectors++;
        if ({mux_en_2, busy_2, adc_start_2} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs_2: got %b, expected 000", {mux_en_2, busy_2, adc_start_2});
        end
        rst = 1'b0; enable = 1'b0; enable_2 = 1'b0; ch_mask = '0; ch_mask_2 = '0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle_busy: got %b, expected 0", busy);
        end
    endtask

    // Full scan on channels 0,2,7, settle spacing, period restart, and a
    // mid-scan mask change that only takes effect at the next scan start.
    task automatic test_single_scan();
        logic es, ev, ed, em;
        logic [CH_W-1:0] ec;
        logic [DATA_W-1:0] edat;
        repeat (3) @(negedge clk);
        ch_mask = 8'b1000_0101; enable = 1'b1;
        for (int r = 0; r <= 108; r++) begin
            @(negedge clk);
            es = (r == 4 || r == 11 || r == 18 || r == 104);
            ev = (r == 7 || r == 14 || r == 21 || r == 107);
            ed = (r == 21 || r == 107);
            vectors++;
            if (adc_start !== es) begin
                miscompares++;
                $display("[TB] FAIL scan_adc_start rel %0d: got %b, expected %b", r, adc_start, es);
            end
            vectors++;
            if (res_valid !== ev) begin
                miscompares++;
                $display("[TB] FAIL scan_res_valid rel %0d: got %b, expected %b", r, res_valid, ev);
            end
            vectors++;
            if (scan_done !== ed) begin
                miscompares++;
                $display("[TB] FAIL scan_done rel %0d: got %b, expected %b", r, scan_done, ed);
            end
            if (ev) begin
                ec   = (r == 14) ? 3'd2 : (r == 21) ? 3'd7 : 3'd0;
                edat = (r == 14) ? 24'd32 : (r == 21) ? 24'd112 : 24'd0;
                vectors++;
                if (res_ch !== ec || res_data !== edat) begin
                    miscompares++;
                    $display("[TB] FAIL scan_result rel %0d: got ch %0d data %0d, expected ch %0d data %0d",
                             r, res_ch, res_data, ec, edat);
                end
            end
            if (r == 0 || r == 7 || r == 14 || r == 100) begin
                ec = (r == 7) ? 3'd2 : (r == 14) ? 3'd7 : 3'd0;
                vectors++;
                if (mux_sel !== ec) begin
                    miscompares++;
                    $display("[TB] FAIL scan_mux_sel rel %0d: got %0d, expected %0d", r, mux_sel, ec);
                end
            end
            if (r == 0 || r == 21 || r == 50 || r == 100) begin
                em = (r == 0 || r == 100);
                vectors++;
                if (mux_en !== em || busy !== 1'b1 || overrun_flag !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL scan_en_busy rel %0d: got en %b busy %b ovr %b, expected en %b busy 1 ovr 0",
                             r, mux_en, busy, overrun_flag, em);
                end
            end
            if (r == 5) ch_mask = 8'h01;
            if (r == 108) enable = 1'b0;
        end
    endtask

    // ch2 never answers: timeout at adc_start+20, no result, scan goes on.
    task automatic test_timeout();
        logic es, ev, ef;
        repeat (3) @(negedge clk);
        silent_1 = 2; ch_mask = 8'b1000_0101; enable = 1'b1;
        for (int r = 0; r <= 46; r++) begin
            @(negedge clk);
            es = (r == 4 || r == 11 || r == 35);
            ev = (r == 7 || r == 38);
            vectors++;
            if (adc_start !== es) begin
                miscompares++;
                $display("[TB] FAIL to_adc_start rel %0d: got %b, expected %b", r, adc_start, es);
            end
            vectors++;
            if (res_valid !== ev || scan_done !== (r == 38)) begin
                miscompares++;
                $display("[TB] FAIL to_res_done rel %0d: got valid %b done %b, expected %b %b",
                         r, res_valid, scan_done, ev, (r == 38));
            end
            if (r == 38) begin
                vectors++;
                if (res_ch !== 3'd7 || res_data !== 24'd112) begin
                    miscompares++;
                    $display("[TB] FAIL to_last_result: got ch %0d data %0d, expected ch 7 data 112", res_ch, res_data);
                end
            end
            if (r == 30 || r == 31 || r == 45 || r == 46) begin
                ef = (r == 31 || r == 45);
                vectors++;
                if (timeout_flag !== ef) begin
                    miscompares++;
                    $display("[TB] FAIL to_flag rel %0d: got %b, expected %b", r, timeout_flag, ef);
                end
            end
            if (r == 45) err_clr = 1'b1;
            if (r == 46) begin
                err_clr = 1'b0; enable = 1'b0; silent_1 = -1;
            end
        end
    endtask

    // enable drops during CONVERT of ch0: the result still arrives, then idle.
    task automatic test_disable_convert();
        repeat (3) @(negedge clk);
        ch_mask = 8'b1000_0101; enable = 1'b1;
        for (int r = 0; r <= 16; r++) begin
            @(negedge clk);
            if (r == 7) begin
                vectors++;
                if (res_valid !== 1'b1 || res_ch !== 3'd0 || scan_done !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL dc_result: got valid %b ch %0d done %b, expected 1 0 0", res_valid, res_ch, scan_done);
                end
                vectors++;
                if (busy !== 1'b0 || mux_en !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL dc_idle: got busy %b en %b, expected 0 0", busy, mux_en);
                end
            end
            if (r > 7) begin
                vectors++;
                if (adc_start !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL dc_no_start rel %0d: got %b, expected 0", r, adc_start);
                end
            end
            if (r == 5) enable = 1'b0;
        end
    endtask

    // enable drops during SETTLE: idle on the next edge and no adc_start.
    task automatic test_disable_settle();
        repeat (3) @(negedge clk);
        ch_mask = 8'b1000_0101; enable = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            vectors++;
            if (adc_start !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL ds_no_start rel %0d: got %b, expected 0", r, adc_start);
            end
            if (r == 1 || r == 3) begin
                vectors++;
                if (busy !== (r == 1) || mux_en !== (r == 1)) begin
                    miscompares++;
                    $display("[TB] FAIL ds_busy_en rel %0d: got busy %b en %b, expected %b", r, busy, mux_en, (r == 1));
                end
            end
            if (r == 2) enable = 1'b0;
        end
    endtask

    // 30-cycle period, 3 channels, 10-cycle ADC: overrun flag, restart one
    // cycle after scan_done, and err_clr losing to a same-cycle overrun.
    task automatic test_overrun();
        logic es, ev, ed, ef;
        repeat (3) @(negedge clk);
        ch_mask_2 = 8'h07; enable_2 = 1'b1;
        for (int r = 0; r <= 89; r++) begin
            @(negedge clk);
            es = (r == 4 || r == 18 || r == 32 || r == 47 || r == 61 || r == 75);
            ev = (r == 14 || r == 28 || r == 42 || r == 57 || r == 71 || r == 85);
            ed = (r == 42 || r == 85);
            vectors++;
            if (adc_start_2 !== es) begin
                miscompares++;
                $display("[TB] FAIL ov_adc_start rel %0d: got %b, expected %b", r, adc_start_2, es);
            end
            vectors++;
            if (res_valid_2 !== ev || scan_done_2 !== ed) begin
                miscompares++;
                $display("[TB] FAIL ov_res_done rel %0d: got valid %b done %b, expected %b %b",
                         r, res_valid_2, scan_done_2, ev, ed);
            end
            if (r == 29 || r == 30 || r == 36 || r == 88 || r == 89) begin
                ef = (r != 29 && r != 89);
                vectors++;
                if (overrun_flag_2 !== ef) begin
                    miscompares++;
                    $display("[TB] FAIL ov_flag rel %0d: got %b, expected %b", r, overrun_flag_2, ef);
                end
            end
            if (r == 42 || r == 43 || r == 86) begin
                vectors++;
                if (mux_en_2 !== (r != 42) || busy_2 !== 1'b1 || mux_sel_2 !== ((r == 42) ? 3'd2 : 3'd0)) begin
                    miscompares++;
                    $display("[TB] FAIL ov_restart rel %0d: got en %b busy %b sel %0d", r, mux_en_2, busy_2, mux_sel_2);
                end
            end
            if (r == 35 || r == 88) err_clr_2 = 1'b1;
            if (r == 36) err_clr_2 = 1'b0;
            if (r == 89) begin
                err_clr_2 = 1'b0; enable_2 = 1'b0;
            end
        end
    endtask

    // Reset during CONVERT of ch7: all outputs zero next edge, late done ignored.
    task automatic test_reset_mid();
        logic [36:0] obs;
        repeat (3) @(negedge clk);
        ch_mask = 8'b1000_0100; enable = 1'b1;
        for (int r = 0; r <= 20; r++) begin
            @(negedge clk);
            if (r == 7) begin
                vectors++;
                if (res_valid !== 1'b1 || res_ch !== 3'd2 || res_data !== 24'd32) begin
                    miscompares++;
                    $display("[TB] FAIL rm_pre_result: got valid %b ch %0d data %0d, expected 1 2 32", res_valid, res_ch, res_data);
                end
            end
            if (r == 13) begin
                obs = {mux_sel, mux_en, adc_start, res_valid, res_ch, res_data,
                       scan_done, busy, timeout_flag, overrun_flag};
                vectors++;
                if (obs !== 37'd0) begin
                    miscompares++;
                    $display("[TB] FAIL rm_outputs: got %0h, expected 0", obs);
                end
            end
            if (r > 13) begin
                vectors++;
                if (res_valid !== 1'b0 || adc_start !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rm_late_done rel %0d: got valid %b start %b, expected 0 0", r, res_valid, adc_start);
                end
            end
            if (r == 12) begin
                rst = 1'b1; enable = 1'b0;
            end
            if (r == 13) rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_timeout();
        test_disable_convert();
        test_disable_settle();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
